avalon_streaming_tester: RTL and testbench
==========================================

AVALON_STREAMING_TESTER -- requirements
Module: avalon_streaming_tester

Interface
REQ-001 The block SHALL be a self-checking Avalon-ST traffic source/sink that drives a streaming DUT sink port and consumes that DUT's source port.
REQ-002 Parameter DATA_W, 8, data word width.
REQ-003 Parameter LEN_W, 16, width of the length and error-count fields.
REQ-004 Parameter READY_PATTERN, 8'hFF, per-cycle asi_ready enable mask.
REQ-005 Parameter TIMEOUT, 1024, idle cycles allowed before a run aborts.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle run request.
REQ-009 len  in  LEN_W  words per run, sampled with start.
REQ-010 seed  in  DATA_W  first data word, sampled with start.
REQ-011 aso_valid  out  1  stimulus word valid (drives DUT sink valid).
REQ-012 aso_data  out  DATA_W  stimulus word.
REQ-013 aso_ready  in  1  DUT sink ready.
REQ-014 asi_valid  in  1  DUT source valid.
REQ-015 asi_data  in  DATA_W  DUT source data.
REQ-016 asi_ready  out  1  checker ready (drives DUT source ready).
REQ-017 busy  out  1  run in progress.
REQ-018 done  out  1  run finished; held until next start or reset.
REQ-019 error  out  1  sticky: any mismatch or timeout in current run.
REQ-020 timeout  out  1  sticky: current run aborted by watchdog.
REQ-021 err_count  out  LEN_W  mismatched words in current run, saturating.

Function
REQ-022 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-023 IDLE or DONE, start=1, len!=0: latch len and seed, clear tx_cnt, rx_cnt, phase, idle counter, error, timeout, err_count; enter RUN next cycle.
REQ-024 IDLE or DONE, start=1, len=0: clear flags and counters, enter DONE; done=1 next cycle, no transfers.
REQ-025 start in RUN SHALL be ignored.
REQ-026 RUN: aso_valid=1 while tx_cnt<len; aso_data=(seed+tx_cnt) mod 2^DATA_W.
REQ-027 Source transfer iff aso_valid&&aso_ready on a rising edge; tx_cnt increments by one per transfer.
REQ-028 aso_data and aso_valid SHALL stay stable while aso_valid=1 and aso_ready=0.
REQ-029 RUN: asi_ready=READY_PATTERN[phase] while rx_cnt<len, else 0; phase (3 bits) increments every RUN cycle, wrapping 7->0.
REQ-030 Sink transfer iff asi_valid&&asi_ready; expected word=(seed+rx_cnt) mod 2^DATA_W; rx_cnt increments.
REQ-031 Mismatch: err_count increments (held at 2^LEN_W-1); error=1 from next cycle.
REQ-032 Simultaneous source and sink transfers in one cycle SHALL both be counted.
REQ-033 Idle counter clears on any transfer, else increments in RUN; reaching TIMEOUT sets timeout=1, error=1, enters DONE.
REQ-034 RUN -> DONE on the cycle the len-th sink transfer completes; done=1, busy=0 next cycle.
REQ-035 DONE: aso_valid=0, asi_ready=0, busy=0, done=1; error/timeout/err_count held.
REQ-036 busy=1 exactly while in RUN.

Reset
REQ-037 reset=1 on a rising edge: state IDLE; aso_valid, aso_data, asi_ready, busy, done, error, timeout, err_count, tx_cnt, rx_cnt, phase, idle counter all 0.
REQ-038 Reset mid-RUN SHALL abort immediately without completing or flagging; outstanding words are discarded.
REQ-039 Reset has priority over start.

Verification
REQ-040 Loopback, aso->asi via 10-deep FIFO, len=20, seed=8'h30, READY_PATTERN=8'hFF -> 20 words 30h..43h sent and received, done=1, error=0, err_count=0.
REQ-041 Same, seed=8'hFE, len=4 -> words FEh,FFh,00h,01h; wrap checked clean, error=0.
REQ-042 READY_PATTERN=8'hA5, aso_ready toggling every cycle, len=50 -> aso_data stable while stalled, done=1, error=0.
REQ-043 Inject corruption: data bit0 flipped on 3rd and 7th words, len=10 -> err_count=2, error=1, done=1.
REQ-044 aso_ready held 0, TIMEOUT=16, len=5 -> timeout=1, error=1, done=1 after 16 idle RUN cycles.
REQ-045 reset pulsed 1 cycle mid-RUN at tx_cnt=5 -> all outputs 0 next cycle; new start len=3 runs clean to done=1.

Source files
------------

// File: rtl/avalon_streaming_tester.sv
// avalon_streaming_tester: Avalon-ST source/sink tester; clk/reset, start+len+seed run request, aso_* stimulus out, asi_* checked in, busy/done/error/timeout/err_count status
module avalon_streaming_tester #(
  parameter int DATA_W = 8,
  parameter int LEN_W = 16,
  parameter logic [7:0] READY_PATTERN = 8'hFF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  output logic              aso_valid,
  output logic [DATA_W-1:0] aso_data,
  input  logic              aso_ready,
  input  logic              asi_valid,
  input  logic [DATA_W-1:0] asi_data,
  output logic              asi_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [LEN_W-1:0]  err_count
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nx;
  logic [LEN_W-1:0] r_len, r_tx_cnt, r_rx_cnt, w_len_nx, w_tx_nx, w_rx_nx, w_err_cnt_nx;
  logic [DATA_W-1:0] r_seed, w_seed_nx;
  logic [2:0] r_phase, w_phase_nx;
  logic [IDLE_W-1:0] r_idle, w_idle_nx, w_idle_inc;
  logic w_start_ok, w_tx_xfer, w_rx_xfer, w_mismatch, w_tmo, w_last, w_run_nx, w_error_nx, w_timeout_nx;
  always_comb begin
    w_start_ok = start && r_state != S_RUN;
    w_tx_xfer = r_state == S_RUN && aso_valid && aso_ready;
    w_rx_xfer = r_state == S_RUN && asi_ready && asi_valid;
    w_mismatch = w_rx_xfer && asi_data != r_seed + DATA_W'(r_rx_cnt);
    w_idle_inc = r_idle + IDLE_W'(1);
    w_tmo = r_state == S_RUN && !w_tx_xfer && !w_rx_xfer && w_idle_inc == IDLE_W'(TIMEOUT);
    w_last = w_rx_xfer && r_rx_cnt + LEN_W'(1) == r_len;
    w_state_nx = w_start_ok ? (len == '0 ? S_DONE : S_RUN) : (w_last || w_tmo) ? S_DONE : r_state;
    w_len_nx = w_start_ok ? len : r_len;
    w_seed_nx = w_start_ok ? seed : r_seed;
    w_tx_nx = w_start_ok ? '0 : r_tx_cnt + LEN_W'(w_tx_xfer);
    w_rx_nx = w_start_ok ? '0 : r_rx_cnt + LEN_W'(w_rx_xfer);
    w_phase_nx = w_start_ok ? '0 : r_state == S_RUN ? r_phase + 3'd1 : r_phase;
    w_idle_nx = (w_start_ok || w_tx_xfer || w_rx_xfer) ? '0 : r_state == S_RUN ? w_idle_inc : r_idle;
    w_err_cnt_nx = w_start_ok ? '0 : (w_mismatch && err_count != '1) ? err_count + LEN_W'(1) : err_count;
    w_error_nx = !w_start_ok && (error || w_mismatch || w_tmo);
    w_timeout_nx = !w_start_ok && (timeout || w_tmo);
    w_run_nx = w_state_nx == S_RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len <= '0;
      r_seed <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_phase <= '0;
      r_idle <= '0;
      aso_valid <= 1'b0;
      aso_data <= '0;
      asi_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_len <= w_len_nx;
      r_seed <= w_seed_nx;
      r_tx_cnt <= w_tx_nx;
      r_rx_cnt <= w_rx_nx;
      r_phase <= w_phase_nx;
      r_idle <= w_idle_nx;
      aso_valid <= w_run_nx && w_tx_nx < w_len_nx;
      aso_data <= w_seed_nx + DATA_W'(w_tx_nx);
      asi_ready <= w_run_nx && w_rx_nx < w_len_nx && READY_PATTERN[w_phase_nx];
      busy <= w_run_nx;
      done <= w_state_nx == S_DONE;
      error <= w_error_nx;
      timeout <= w_timeout_nx;
      err_count <= w_err_cnt_nx;
    end
  end
endmodule

// File: tb/tb_avalon_streaming_tester.sv
// tb_avalon_streaming_tester: loopback bench for two tester instances (pattern FF/timeout 16, pattern A5/timeout 1024)
module tb_avalon_streaming_tester;
  localparam logic [7:0] PAT0 = 8'hFF;
  localparam logic [7:0] PAT1 = 8'hA5;
  typedef struct {
    int k; int l; logic [7:0] s; int m; logic [63:0] cm;
    int e_err; logic e_error; logic e_tmo; int e_words; int e_cyc;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic start [2];
  logic [15:0] len [2];
  logic [7:0] seed [2];
  logic aso_valid [2];
  logic [7:0] aso_data [2];
  logic aso_ready [2];
  logic asi_valid [2];
  logic [7:0] asi_data [2];
  logic asi_ready [2];
  logic busy [2];
  logic done [2];
  logic error [2];
  logic timeout [2];
  logic [15:0] err_count [2];
  logic [7:0] fb [2][16];
  int wp [2], rp [2], fcnt [2], n_tx [2], n_rx [2], cyc [2], mode [2], cur_len [2];
  logic [7:0] cur_seed [2];
  logic [63:0] corrupt [2];
  logic tgl [2];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vec [8];

  avalon_streaming_tester #(.READY_PATTERN(PAT0), .TIMEOUT(16)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .len(len[0]), .seed(seed[0]),
    .aso_valid(aso_valid[0]), .aso_data(aso_data[0]), .aso_ready(aso_ready[0]),
    .asi_valid(asi_valid[0]), .asi_data(asi_data[0]), .asi_ready(asi_ready[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .timeout(timeout[0]), .err_count(err_count[0]));
  avalon_streaming_tester #(.READY_PATTERN(PAT1)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .len(len[1]), .seed(seed[1]),
    .aso_valid(aso_valid[1]), .aso_data(aso_data[1]), .aso_ready(aso_ready[1]),
    .asi_valid(asi_valid[1]), .asi_data(asi_data[1]), .asi_ready(asi_ready[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .timeout(timeout[1]), .err_count(err_count[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs(input int k);
    return {34'd0, aso_valid[k], asi_ready[k], busy[k], done[k], error[k], timeout[k], aso_data[k], err_count[k]};
  endfunction

  // Loopback through a 10-deep FIFO: inputs change just after the rising edge,
  // transfers are accounted at the falling edge for the next rising edge.
  initial begin
    logic g;
    logic [7:0] pat;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        tgl[k] = ~tgl[k];
        g = mode[k] == 0 ? 1'b1 : mode[k] == 1 ? tgl[k] : mode[k] == 2 ? 1'b0 : ($urandom_range(3) != 0);
        aso_ready[k] = g && fcnt[k] < 10;
        asi_valid[k] = fcnt[k] > 0;
        asi_data[k] = fb[k][rp[k]] ^ {7'd0, (n_rx[k] < 64) && corrupt[k][n_rx[k]]};
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (busy[k] && !reset) begin
          pat = k == 0 ? PAT0 : PAT1;
          chk("aso_valid", aso_valid[k], n_tx[k] < cur_len[k]);
          if (n_tx[k] < cur_len[k]) chk("aso_data", aso_data[k], 8'(cur_seed[k] + n_tx[k]));
          chk("asi_ready", asi_ready[k], n_rx[k] < cur_len[k] && pat[cyc[k] % 8]);
          if (asi_valid[k] && asi_ready[k]) begin
            chk("rx_word", fb[k][rp[k]], 8'(cur_seed[k] + n_rx[k]));
            rp[k] = (rp[k] + 1) % 16;
            fcnt[k]--;
            n_rx[k]++;
          end
          if (aso_valid[k] && aso_ready[k]) begin
            fb[k][wp[k]] = aso_data[k];
            wp[k] = (wp[k] + 1) % 16;
            fcnt[k]++;
            n_tx[k]++;
          end
          cyc[k]++;
        end
      end
    end
  end

  task automatic begin_run(input int k, input int l, input logic [7:0] s, input int m, input logic [63:0] cm);
    @(posedge clk);
    #1;
    mode[k] = m; corrupt[k] = cm; cur_len[k] = l; cur_seed[k] = s;
    n_tx[k] = 0; n_rx[k] = 0; cyc[k] = 0; fcnt[k] = 0; wp[k] = 0; rp[k] = 0;
    start[k] = 1'b1; len[k] = 16'(l); seed[k] = s;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  task automatic finish_run(input string tg, input int k, input int e_err, input logic e_error,
                            input logic e_tmo, input int e_words, input int e_cyc);
    int bc;
    logic got;
    bc = 0;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done[k]) begin
        got = 1'b1;
        break;
      end
      if (busy[k]) bc++;
    end
    chk({tg, "_done"}, got, 1);
    chk({tg, "_busy"}, busy[k], 0);
    chk({tg, "_error"}, error[k], e_error);
    chk({tg, "_timeout"}, timeout[k], e_tmo);
    chk({tg, "_err_count"}, err_count[k], e_err);
    chk({tg, "_tx_words"}, n_tx[k], e_words);
    chk({tg, "_rx_words"}, n_rx[k], e_words);
    chk({tg, "_quiet"}, {aso_valid[k], asi_ready[k]}, 0);
    if (e_cyc >= 0) chk({tg, "_run_cycles"}, bc, e_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int l, e;
    logic [7:0] s;
    logic [63:0] cm, mask;
    vec[0] = '{0, 20, 8'h30, 0, 64'h0, 0, 1'b0, 1'b0, 20, -1};
    vec[1] = '{0, 4, 8'hFE, 0, 64'h0, 0, 1'b0, 1'b0, 4, -1};
    vec[2] = '{1, 50, 8'h80, 1, 64'h0, 0, 1'b0, 1'b0, 50, -1};
    vec[3] = '{0, 10, 8'h00, 0, 64'h44, 2, 1'b1, 1'b0, 10, -1};
    vec[4] = '{0, 5, 8'h11, 2, 64'h0, 0, 1'b1, 1'b1, 0, 16};
    vec[5] = '{0, 0, 8'h55, 0, 64'h0, 0, 1'b0, 1'b0, 0, 0};
    vec[6] = '{1, 1, 8'hFF, 0, 64'h0, 0, 1'b0, 1'b0, 1, -1};
    vec[7] = '{1, 12, 8'hC3, 0, 64'h801, 2, 1'b1, 1'b0, 12, -1};
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; len[k] = '0; seed[k] = '0;
      aso_ready[k] = 1'b0; asi_valid[k] = 1'b0; asi_data[k] = '0;
      mode[k] = 0; corrupt[k] = '0; tgl[k] = 1'b0; cur_len[k] = 0; cur_seed[k] = '0;
      wp[k] = 0; rp[k] = 0; fcnt[k] = 0; n_tx[k] = 0; n_rx[k] = 0; cyc[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("reset_outs", outs(k), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("idle_outs", outs(k), 0);
    for (int i = 0; i < 8; i++) begin
      begin_run(vec[i].k, vec[i].l, vec[i].s, vec[i].m, vec[i].cm);
      finish_run($sformatf("vec%0d", i), vec[i].k, vec[i].e_err, vec[i].e_error, vec[i].e_tmo, vec[i].e_words, vec[i].e_cyc);
    end
    begin_run(0, 8, 8'h10, 0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    start[0] = 1'b1; len[0] = 16'd1; seed[0] = 8'h00;
    @(posedge clk);
    #1 start[0] = 1'b0;
    finish_run("start_in_run", 0, 0, 1'b0, 1'b0, 8, -1);
    begin_run(0, 20, 8'h40, 0, 64'h0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (n_tx[0] >= 5) break;
    end
    chk("mid_run_reached_tx5", n_tx[0] >= 5, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_run_reset_outs", outs(0), 0);
    begin_run(0, 3, 8'h70, 0, 64'h0);
    finish_run("after_reset", 0, 0, 1'b0, 1'b0, 3, -1);
    for (int i = 0; i < 12; i++) begin
      l = $urandom_range(40, 1);
      s = 8'($urandom);
      cm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      mask = (64'd1 << l) - 64'd1;
      e = $countones(cm & mask);
      begin_run(1, l, s, 3, cm);
      finish_run($sformatf("rnd%0d", i), 1, e, e != 0, 1'b0, l, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
